// File: rtl/sdram_init_cfg.sv
// sdram_init_cfg: parametrised SDRAM power-up initialisation sequencer.
// Issues NOP wait, PRECHARGE all, AR_TIMES x AUTO_REFRESH and LOAD_MODE_REGISTER,
// then sits in END until init_req asks for a re-init (power-up wait skipped).
// Optional feature macro SDRAM_INIT_EMR_EN adds an extended mode register load
// (ba=10, addr=EMR_VALUE) followed by a T_MRD_CLK wait before END.
// Ports:
//   sys_clk, sys_rst_n : clock, asynchronous active-low reset
//   init_req           : re-init pulse, honoured only in END
//   init_cmd           : {cs#,ras#,cas#,we#}, registered
//   init_ba, init_addr : bank and address, registered
//   init_busy/init_end : sequence in progress / init complete (complementary)
module sdram_init_cfg #(
    parameter int         CLK_FREQ_MHZ = 100,
    parameter int         POWERUP_US   = 100,
    parameter int         T_RP_CLK     = 2,
    parameter int         T_RFC_CLK    = 7,
    parameter int         T_MRD_CLK    = 2,
    parameter int         AR_TIMES     = 2,
    parameter int         ADDR_W       = 13,
    parameter logic [2:0] CAS_LAT      = 3'd3,
    parameter logic       BURST_TYPE   = 1'b0,
    parameter logic [2:0] BURST_LEN    = 3'b111,
    parameter logic       WB_MODE      = 1'b0
`ifdef SDRAM_INIT_EMR_EN
    ,
    parameter logic [ADDR_W-1:0] EMR_VALUE = '0
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              init_req,
    output logic [3:0]        init_cmd,
    output logic [1:0]        init_ba,
    output logic [ADDR_W-1:0] init_addr,
    output logic              init_busy,
    output logic              init_end
);
    localparam int PU    = CLK_FREQ_MHZ * POWERUP_US;
    localparam int W_PU  = PU < 1 ? 1 : PU;
    localparam int W_RP  = T_RP_CLK < 1 ? 1 : T_RP_CLK;
    localparam int W_RFC = T_RFC_CLK < 1 ? 1 : T_RFC_CLK;
    localparam int W_MRD = T_MRD_CLK < 1 ? 1 : T_MRD_CLK;
    localparam int M1    = W_PU > W_RP ? W_PU : W_RP;
    localparam int M2    = W_RFC > W_MRD ? W_RFC : W_MRD;
    localparam int W_MAX = M1 > M2 ? M1 : M2;
    localparam int CW    = $clog2(W_MAX) + 1;
    localparam logic [3:0] AR_N = 4'(AR_TIMES);
    localparam logic [3:0] NOP = 4'b0111, PRE_C = 4'b0010, AR_C = 4'b0001, LMR_C = 4'b0000;
    localparam logic [ADDR_W-1:0] LMR_ADDR =
        {{(ADDR_W-10){1'b0}}, WB_MODE, 2'b00, CAS_LAT, BURST_TYPE, BURST_LEN};

    typedef enum logic [3:0] {IDLE, PRE, TRP, AR, TRFC, LMR, TMRD, EMR, TEMR, END} state_t;

    state_t            state, nxt;
    logic [CW-1:0]     cnt, wait_last;
    logic [3:0]        rcnt;
    logic              done;
    logic [3:0]        cmd_d;
    logic [1:0]        ba_d;
    logic [ADDR_W-1:0] addr_d;

    // wait counter restarts whenever the state changes, so it clears on every wait entry
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rcnt      <= '0;
            init_cmd  <= NOP;
            init_ba   <= 2'b11;
            init_addr <= '1;
            init_busy <= 1'b1;
            init_end  <= 1'b0;
        end else begin
            state     <= nxt;
            cnt       <= (nxt != state) ? '0 : cnt + 1'b1;
            rcnt      <= (nxt == PRE) ? '0 : (state == AR) ? rcnt + 1'b1 : rcnt;
            init_cmd  <= cmd_d;
            init_ba   <= ba_d;
            init_addr <= addr_d;
            init_busy <= state != END;
            init_end  <= state == END;
        end
    end

    always_comb begin
        wait_last = state == IDLE ? CW'(W_PU - 1) :
                    state == TRP  ? CW'(W_RP - 1) :
                    state == TRFC ? CW'(W_RFC - 1) : CW'(W_MRD - 1);
        done = cnt == wait_last;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: nxt = done ? PRE : IDLE;
            PRE:  nxt = TRP;
            TRP:  nxt = done ? AR : TRP;
            AR:   nxt = TRFC;
            TRFC: nxt = !done ? TRFC : (rcnt < AR_N) ? AR : LMR;
            LMR:  nxt = TMRD;
`ifdef SDRAM_INIT_EMR_EN
            TMRD: nxt = done ? EMR : TMRD;
            EMR:  nxt = TEMR;
            TEMR: nxt = done ? END : TEMR;
`else
            TMRD: nxt = done ? END : TMRD;
`endif
            END:  nxt = init_req ? PRE : END;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        cmd_d  = state == PRE ? PRE_C : state == AR ? AR_C : state == LMR ? LMR_C : NOP;
        ba_d   = state == LMR ? 2'b00 : 2'b11;
        addr_d = state == LMR ? LMR_ADDR : '1;
`ifdef SDRAM_INIT_EMR_EN
        if (state == EMR) begin
            cmd_d  = LMR_C;
            ba_d   = 2'b10;
            addr_d = EMR_VALUE;
        end
`endif
    end
endmodule

// File: tb/tb_sdram_init_cfg.sv
// tb_sdram_init_cfg: scoreboard bench for sdram_init_cfg; u0 runs the default
// timings (P=10) through init, ignored/honoured init_req and a mid-TRFC reset,
// u1 covers AR_TIMES=4, T_RFC_CLK=3, T_RP_CLK=0 and a zero power-up count.
module tb_sdram_init_cfg;
    logic        clk = 1'b0;
    logic        rst_n, req0, req1;
    logic [3:0]  cmd0, cmd1;
    logic [1:0]  ba0, ba1;
    logic [12:0] a0, a1;
    logic        busy0, busy1, end0, end1;
    int          n_chk = 0;
    int          n_pass = 0;
    logic [20:0] q0[$];
    logic [20:0] q1[$];

    localparam logic [20:0] NOPW = {4'b0111, 2'b11, 13'h1fff, 1'b1, 1'b0};
    localparam logic [20:0] ENDW = {4'b0111, 2'b11, 13'h1fff, 1'b0, 1'b1};
    localparam logic [20:0] PREW = {4'b0010, 2'b11, 13'h1fff, 1'b1, 1'b0};
    localparam logic [20:0] ARW  = {4'b0001, 2'b11, 13'h1fff, 1'b1, 1'b0};
    localparam logic [20:0] LMRW = {4'b0000, 2'b00, 13'h0037, 1'b1, 1'b0};

    always #5 clk = ~clk;

    sdram_init_cfg #(
        .CLK_FREQ_MHZ(1), .POWERUP_US(10)
`ifdef SDRAM_INIT_EMR_EN
        , .EMR_VALUE(13'h0020)
`endif
    ) u0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_req(req0), .init_cmd(cmd0),
        .init_ba(ba0), .init_addr(a0), .init_busy(busy0), .init_end(end0)
    );

    sdram_init_cfg #(
        .CLK_FREQ_MHZ(1), .POWERUP_US(0), .T_RP_CLK(0), .T_RFC_CLK(3), .AR_TIMES(4)
    ) u1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .init_req(req1), .init_cmd(cmd1),
        .init_ba(ba1), .init_addr(a1), .init_busy(busy1), .init_end(end1)
    );

    task automatic check(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
    endtask

    task automatic push(input int d, input logic [20:0] w);
        if (d == 0) q0.push_back(w);
        else q1.push_back(w);
    endtask

    // expected output trace from reset release (pu=1) or from the PRECHARGE output (pu=0)
    task automatic push_seq(input int d, input bit pu);
        int p, trp, trfc, ar, tmrd;
        logic [12:0] emr_a;
        p     = d == 0 ? 10 : 1;
        trp   = d == 0 ? 2 : 1;
        trfc  = d == 0 ? 7 : 3;
        ar    = d == 0 ? 2 : 4;
        tmrd  = 2;
        emr_a = d == 0 ? 13'h0020 : 13'h0000;
        if (pu) repeat (p + 1) push(d, NOPW);
        push(d, PREW);
        repeat (trp) push(d, NOPW);
        repeat (ar) begin
            push(d, ARW);
            repeat (trfc) push(d, NOPW);
        end
        push(d, LMRW);
        repeat (tmrd) push(d, NOPW);
`ifdef SDRAM_INIT_EMR_EN
        push(d, {4'b0000, 2'b10, emr_a, 1'b1, 1'b0});
        repeat (tmrd) push(d, NOPW);
`else
        if (emr_a == 13'h1fff) push(d, NOPW);
`endif
    endtask

    // an empty queue means the block is expected to be resting in END
    task automatic cyc();
        @(negedge clk);
        if (q0.size() == 0) q0.push_back(ENDW);
        if (q1.size() == 0) q1.push_back(ENDW);
        check("u0", {cmd0, ba0, a0, busy0, end0}, q0.pop_front());
        check("u1", {cmd1, ba1, a1, busy1, end1}, q1.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        @(negedge clk);
        check("rst_u0", {cmd0, ba0, a0, busy0, end0}, NOPW);
        check("rst_u1", {cmd1, ba1, a1, busy1, end1}, NOPW);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_seq(0, 1'b1);
        push_seq(1, 1'b1);
        repeat (17) cyc();
        req0 = 1'b1;
        cyc();
        req0 = 1'b0;
        repeat (20) cyc();
        req0 = 1'b1;
        push(0, ENDW);
        push(0, ENDW);
        push_seq(0, 1'b0);
        cyc();
        req0 = 1'b0;
        repeat (15) cyc();
        rst_n = 1'b0;
        #1;
        check("arst_u0", {cmd0, ba0, a0, busy0, end0}, NOPW);
        check("arst_u1", {cmd1, ba1, a1, busy1, end1}, NOPW);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_seq(0, 1'b1);
        push_seq(1, 1'b1);
        repeat (42) cyc();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
